// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared definitions for the programmable clock-enable generator.
//   - CNT_W_DEF     : default width of the half-period counter and divisor
//   - DEF_HALF_1HZ  : reset half-period (1 Hz output from a 50 MHz clock)
//   - state_e       : controller state encoding
//   - is_ready_state: states in which a new divisor can be accepted
package clkdiv_pkg;

    localparam int CNT_W_DEF    = 26;
    localparam int DEF_HALF_1HZ = 25_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    function automatic logic is_ready_state(input state_e st);
        return (st == ST_IDLE) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: firmware-facing control/status bundle of clkdiv_ctrl.
//   master: drives run, cfg_valid, cfg_half; observes status and clock outputs
//   slave : the controller side
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic             active;

    modport master (
        output run, cfg_valid, cfg_half,
        input  cfg_ready, cfg_err, clk_out, tick_rise, tick_fall, active
    );

    modport slave (
        input  run, cfg_valid, cfg_half,
        output cfg_ready, cfg_err, clk_out, tick_rise, tick_fall, active
    );

endinterface

// File: rtl/clkdiv_ctrl_half_period_cnt.sv
// half_period_cnt: counts 0..half_i-1 while enabled, wrapping to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : advance the counter
//   clr_i      : force the counter to 0 (has priority over en_i)
//   half_i     : active half-period (never 0)
//   wrap_o     : counter is at its last value, half_i-1
module half_period_cnt
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wrap_o = (cnt_q == (half_i - ONE));

    // Next count: clear, wrap or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (wrap_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: runtime-programmable, glitch-free clock divider / tick generator.
//   clk50m : system clock
//   rst_n  : asynchronous active-low reset (deassertion synchronised externally)
//   bus    : run level, cfg_valid/cfg_half/cfg_ready handshake, cfg_err pulse,
//            clk_out square wave, tick_rise/tick_fall enables, active status.
// New divisors accepted while running are held pending and applied only at the
// end of a full period (the low-phase wrap), so clk_out never produces a runt.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_1HZ
) (
    input  logic        clk50m,
    input  logic        rst_n,
    clkdiv_if.slave     bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_fall_q, tick_fall_d;
    logic             cfg_err_q, cfg_err_d;
    logic             active_q, active_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic xfer_s, cfg_zero_s, xfer_ok_s;
    logic wrap_s, go_idle_s, cnt_clr_s, cnt_en_s;

    assign xfer_s     = bus.cfg_valid & cfg_ready_q;
    assign cfg_zero_s = (bus.cfg_half == '0);
    assign xfer_ok_s  = xfer_s & ~cfg_zero_s;
    assign cnt_en_s   = (state_q != ST_IDLE);

    half_period_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk50m),
        .rst_n  (rst_n),
        .en_i   (cnt_en_s),
        .clr_i  (cnt_clr_s),
        .half_i (half_q),
        .wrap_o (wrap_s)
    );

    // Next-state, divisor bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        pend_half_d = pend_half_q;
        pend_vld_d  = pend_vld_q;
        clk_out_d   = clk_out_q;
        tick_rise_d = 1'b0;
        tick_fall_d = 1'b0;
        cfg_err_d   = xfer_s & cfg_zero_s;
        go_idle_s   = 1'b0;
        cnt_clr_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A divisor given together with the start is used from that period.
                if (xfer_ok_s) begin
                    half_d = bus.cfg_half;
                end else begin
                    half_d = half_q;
                end
                if (bus.run) begin
                    state_d     = ST_RUN;
                    clk_out_d   = 1'b1;
                    tick_rise_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_PEND: begin
                if ((state_q == ST_RUN) && xfer_ok_s) begin
                    pend_half_d = bus.cfg_half;
                    pend_vld_d  = 1'b1;
                end else begin
                    pend_vld_d  = pend_vld_q;
                end
                if (!bus.run) begin
                    // Stop: finish a high phase; a low phase ends immediately.
                    if (clk_out_q && !wrap_s) begin
                        state_d = ST_STOP;
                    end else begin
                        go_idle_s   = 1'b1;
                        tick_fall_d = clk_out_q;
                    end
                end else if (wrap_s) begin
                    clk_out_d   = ~clk_out_q;
                    tick_rise_d = ~clk_out_q;
                    tick_fall_d = clk_out_q;
                    // Low-phase wrap is the full-period boundary.
                    if (pend_vld_q && !clk_out_q) begin
                        half_d     = pend_half_q;
                        pend_vld_d = 1'b0;
                        state_d    = ST_RUN;
                    end else begin
                        state_d = pend_vld_d ? ST_PEND : ST_RUN;
                    end
                end else begin
                    state_d = pend_vld_d ? ST_PEND : ST_RUN;
                end
            end
            ST_STOP: begin
                if (wrap_s) begin
                    go_idle_s   = 1'b1;
                    tick_fall_d = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase

        // Entry to IDLE: park the output low and commit any pending divisor.
        if (go_idle_s) begin
            state_d    = ST_IDLE;
            clk_out_d  = 1'b0;
            cnt_clr_s  = 1'b1;
            half_d     = pend_vld_d ? pend_half_d : half_q;
            pend_vld_d = 1'b0;
        end else begin
            cnt_clr_s = 1'b0;
        end

        active_d    = (state_d != ST_IDLE);
        cfg_ready_d = is_ready_state(state_d);
    end

    // State, divisor and output registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            half_q      <= CNT_W'(DEF_HALF);
            pend_half_q <= '0;
            pend_vld_q  <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            active_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_vld_q  <= pend_vld_d;
            clk_out_q   <= clk_out_d;
            tick_rise_q <= tick_rise_d;
            tick_fall_q <= tick_fall_d;
            cfg_err_q   <= cfg_err_d;
            active_q    <= active_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign bus.clk_out   = clk_out_q;
    assign bus.tick_rise = tick_rise_q;
    assign bus.tick_fall = tick_fall_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.active    = active_q;
    assign bus.cfg_ready = cfg_ready_q;

endmodule
